// File: rtl/stopwatch_pkg.sv
// Shared stopwatch constants and BCD digit helpers.
// Purely combinational functions; no state, no flow control.
package stopwatch_pkg;

  localparam int DIGIT_W = 4;
  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;
  localparam int HR_MOD  = 24;

  function automatic logic [DIGIT_W-1:0] bcd_tens(input logic [6:0] v);
    return DIGIT_W'(v / 7'd10);
  endfunction

  function automatic logic [DIGIT_W-1:0] bcd_units(input logic [6:0] v);
    return DIGIT_W'(v % 7'd10);
  endfunction

endpackage

// File: rtl/bin2bcd2.sv
// Binary 0..99 to two BCD digits, combinational (zero latency).
// No flow control; output follows input every cycle.
module bin2bcd2
  import stopwatch_pkg::*;
(
  input  logic [6:0]         bin,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] units
);

  assign tens  = bcd_tens(bin);
  assign units = bcd_units(bin);

endmodule

// File: rtl/mod_bcd_counter.sv
// Modulo up/down counter with preset, wrap/saturate, cascade pulse and BCD digits.
// All outputs registered (one edge from inputs); clk_en gates stepping, no backpressure.
module mod_bcd_counter
  import stopwatch_pkg::*;
#(
  parameter int MODULUS     = 60,
  parameter int WIDTH       = 7,
  parameter int WRAP        = 1,
  parameter int SKIP_ON_DIR = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic               back,
  input  logic               skip_dir,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  output logic [WIDTH-1:0]   val,
  output logic [DIGIT_W-1:0] high_val,
  output logic [DIGIT_W-1:0] low_val,
  output logic               ovf,
  output logic               sat
);

  if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
    $error("mod_bcd_counter: MODULUS must be in 2..100");
  end
  if ((2 ** WIDTH) < MODULUS) begin : g_bad_width
    $error("mod_bcd_counter: WIDTH too small for MODULUS");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic               last_back;
  logic               dir_change;
  logic               step;
  logic [WIDTH-1:0]   val_nxt;
  logic               ovf_nxt;
  logic               sat_nxt;
  logic [DIGIT_W-1:0] tens_nxt;
  logic [DIGIT_W-1:0] units_nxt;

  // Sampled through reset too, so the first post-reset cycle sees a valid history.
  always_ff @(posedge clk) begin
    last_back <= back;
  end

  assign dir_change = (last_back != back);
  assign step       = clk_en && !((SKIP_ON_DIR != 0) && skip_dir && dir_change);

  always_comb begin
    val_nxt = val;
    ovf_nxt = 1'b0;
    sat_nxt = sat;
    if (load) begin
      val_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      sat_nxt = 1'b0;
    end else if (step) begin
      if (!back) begin
        if (val < MAX_VAL) begin
          val_nxt = val + WIDTH'(1);
          sat_nxt = 1'b0;
        end else if (WRAP != 0) begin
          val_nxt = '0;
          ovf_nxt = 1'b1;
          sat_nxt = 1'b0;
        end else begin
          sat_nxt = 1'b1;
        end
      end else begin
        if (val != '0) begin
          val_nxt = val - WIDTH'(1);
          sat_nxt = 1'b0;
        end else if (WRAP != 0) begin
          val_nxt = MAX_VAL;
          ovf_nxt = 1'b1;
          sat_nxt = 1'b0;
        end else begin
          sat_nxt = 1'b1;
        end
      end
    end
  end

  // Digits decode the next-state value so they land on the same edge as val.
  bin2bcd2 u_bcd (
    .bin   (7'(val_nxt)),
    .tens  (tens_nxt),
    .units (units_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      val      <= '0;
      high_val <= '0;
      low_val  <= '0;
      ovf      <= 1'b0;
      sat      <= 1'b0;
    end else begin
      val      <= val_nxt;
      high_val <= tens_nxt;
      low_val  <= units_nxt;
      ovf      <= ovf_nxt;
      sat      <= sat_nxt;
    end
  end

endmodule

// File: tb/tb_mod_bcd_counter.sv
// Bench for mod_bcd_counter: vector table, corner sequences, random vs. model, cascade.
module tb_mod_bcd_counter;

  logic       clk = 1'b0;
  logic       rst, clk_en, back, skip_dir, load;
  logic [6:0] load_val;

  logic [6:0] a_val;
  logic [3:0] a_high, a_low;
  logic       a_ovf, a_sat;
  logic [4:0] b_val;
  logic [3:0] b_high, b_low;
  logic       b_ovf, b_sat;

  logic       c_rst, c_tick;
  logic [6:0] s_val, m_val;
  logic [3:0] s_high, s_low, m_high, m_low;
  logic       s_ovf, s_sat, m_ovf, m_sat;

  always #5 clk = ~clk;

  mod_bcd_counter #(.MODULUS(60), .WIDTH(7), .WRAP(1), .SKIP_ON_DIR(1)) dut_a (
    .clk(clk), .rst(rst), .clk_en(clk_en), .back(back), .skip_dir(skip_dir),
    .load(load), .load_val(load_val), .val(a_val), .high_val(a_high),
    .low_val(a_low), .ovf(a_ovf), .sat(a_sat));

  mod_bcd_counter #(.MODULUS(24), .WIDTH(5), .WRAP(0), .SKIP_ON_DIR(1)) dut_b (
    .clk(clk), .rst(rst), .clk_en(clk_en), .back(back), .skip_dir(skip_dir),
    .load(load), .load_val(load_val[4:0]), .val(b_val), .high_val(b_high),
    .low_val(b_low), .ovf(b_ovf), .sat(b_sat));

  mod_bcd_counter #(.MODULUS(60), .WIDTH(7), .WRAP(1), .SKIP_ON_DIR(1)) dut_sec (
    .clk(clk), .rst(c_rst), .clk_en(c_tick), .back(1'b0), .skip_dir(1'b0),
    .load(1'b0), .load_val(7'd0), .val(s_val), .high_val(s_high),
    .low_val(s_low), .ovf(s_ovf), .sat(s_sat));

  mod_bcd_counter #(.MODULUS(60), .WIDTH(7), .WRAP(1), .SKIP_ON_DIR(1)) dut_min (
    .clk(clk), .rst(c_rst), .clk_en(s_ovf), .back(1'b0), .skip_dir(1'b0),
    .load(1'b0), .load_val(7'd0), .val(m_val), .high_val(m_high),
    .low_val(m_low), .ovf(m_ovf), .sat(m_sat));

  int errors = 0;
  int checks = 0;

  int ma_v = 0, mb_v = 0;
  bit ma_o = 0, ma_s = 0, mb_o = 0, mb_s = 0;
  bit m_last = 0;

  typedef struct {
    bit rst; bit load; int ld; bit en; bit bk; bit sk; int ev; bit eo;
  } vec_t;
  vec_t tbl[21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: take one step in integer space, then wrap by modulo or clamp.
  function automatic void model(input int m, input bit wrap, input int ld, input int v,
                                input bit s, output int nv, output bit no, output bit ns);
    int t;
    nv = v; no = 0; ns = s;
    if (rst) begin
      nv = 0; ns = 0;
    end else if (load) begin
      nv = (ld > m - 1) ? m - 1 : ld; ns = 0;
    end else if (clk_en && !(skip_dir && (back != m_last))) begin
      t = back ? v - 1 : v + 1;
      if (t >= 0 && t < m) begin
        nv = t; ns = 0;
      end else if (wrap) begin
        nv = (t + m) % m; no = 1; ns = 0;
      end else begin
        ns = 1;
      end
    end
  endfunction

  task automatic cmp_all(input string tag);
    chk({tag, ".a_val"},  a_val,  ma_v);
    chk({tag, ".a_high"}, a_high, ma_v / 10);
    chk({tag, ".a_low"},  a_low,  ma_v % 10);
    chk({tag, ".a_ovf"},  a_ovf,  ma_o);
    chk({tag, ".a_sat"},  a_sat,  ma_s);
    chk({tag, ".b_val"},  b_val,  mb_v);
    chk({tag, ".b_high"}, b_high, mb_v / 10);
    chk({tag, ".b_low"},  b_low,  mb_v % 10);
    chk({tag, ".b_ovf"},  b_ovf,  mb_o);
    chk({tag, ".b_sat"},  b_sat,  mb_s);
  endtask

  task automatic tick(input string tag);
    int  nv;
    bit  no, ns;
    @(posedge clk);
    #1;
    model(60, 1'b1, int'(load_val), ma_v, ma_s, nv, no, ns);
    ma_v = nv; ma_o = no; ma_s = ns;
    model(24, 1'b0, int'(load_val) & 31, mb_v, mb_s, nv, no, ns);
    mb_v = nv; mb_o = no; mb_s = ns;
    m_last = back;
    cmp_all(tag);
  endtask

  task automatic drive(input bit r, input bit l, input int ld, input bit en,
                       input bit bk, input bit sk);
    rst = r; load = l; load_val = 7'(ld); clk_en = en; back = bk; skip_dir = sk;
  endtask

  initial begin
    int sec_pulses, min_pulses;
    drive(1, 0, 0, 0, 0, 0);
    c_rst = 1'b1; c_tick = 1'b0;

    //            rst ld  ldv en bk sk  val ovf   (dut_a, MODULUS=60 wrapping)
    tbl[0]  = '{1, 0,  0, 0, 0, 0,  0, 0};
    tbl[1]  = '{0, 1, 58, 1, 0, 0, 58, 0};
    tbl[2]  = '{0, 0,  0, 1, 0, 0, 59, 0};
    tbl[3]  = '{0, 0,  0, 1, 0, 0,  0, 1};
    tbl[4]  = '{0, 0,  0, 0, 0, 0,  0, 0};
    tbl[5]  = '{0, 1,  1, 0, 0, 0,  1, 0};
    tbl[6]  = '{0, 0,  0, 1, 1, 0,  0, 0};
    tbl[7]  = '{0, 0,  0, 1, 1, 0, 59, 1};
    tbl[8]  = '{0, 0,  0, 0, 1, 0, 59, 0};
    tbl[9]  = '{0, 1, 30, 0, 0, 0, 30, 0};
    tbl[10] = '{0, 0,  0, 1, 1, 1, 30, 0};
    tbl[11] = '{0, 0,  0, 1, 1, 1, 29, 0};
    tbl[12] = '{0, 1, 30, 0, 0, 0, 30, 0};
    tbl[13] = '{0, 0,  0, 1, 1, 0, 29, 0};
    tbl[14] = '{0, 1, 75, 1, 0, 0, 59, 0};
    tbl[15] = '{0, 1, 42, 1, 0, 0, 42, 0};
    tbl[16] = '{0, 1, 59, 0, 0, 0, 59, 0};
    tbl[17] = '{1, 1, 59, 0, 0, 0,  0, 0};
    tbl[18] = '{0, 1, 59, 1, 0, 0, 59, 0};
    tbl[19] = '{0, 0,  0, 1, 0, 0,  0, 1};
    tbl[20] = '{1, 0,  0, 1, 0, 0,  0, 0};

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].rst, tbl[i].load, tbl[i].ld, tbl[i].en, tbl[i].bk, tbl[i].sk);
      tick($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.val", i), a_val, tbl[i].ev);
      chk($sformatf("tbl%0d.ovf", i), a_ovf, tbl[i].eo);
      chk($sformatf("tbl%0d.digits", i), {a_high, a_low},
          {4'(tbl[i].ev / 10), 4'(tbl[i].ev % 10)});
    end

    // Saturating stage (dut_b, MODULUS=24) at both range ends.
    drive(0, 1, 23, 0, 0, 0); tick("sat_ld23");
    drive(0, 0, 0, 1, 0, 0);  tick("sat_up");
    chk("sat_up.b_val", b_val, 23); chk("sat_up.b_sat", b_sat, 1); chk("sat_up.b_ovf", b_ovf, 0);
    drive(0, 0, 0, 1, 1, 0);  tick("sat_dn");
    chk("sat_dn.b_val", b_val, 22); chk("sat_dn.b_sat", b_sat, 0);
    drive(0, 1, 0, 0, 1, 0);  tick("sat_ld0");
    drive(0, 0, 0, 1, 1, 0);  tick("sat_low");
    chk("sat_low.b_val", b_val, 0); chk("sat_low.b_sat", b_sat, 1);
    drive(0, 0, 0, 0, 1, 0);  tick("sat_hold");
    chk("sat_hold.b_sat", b_sat, 1);
    drive(0, 0, 0, 1, 0, 0);  tick("sat_rel");
    chk("sat_rel.b_val", b_val, 1); chk("sat_rel.b_sat", b_sat, 0);

    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 63) == 0);
      load     = ($urandom_range(0, 15) == 0);
      load_val = 7'($urandom_range(0, 127));
      clk_en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) back = ~back;
      skip_dir = 1'($urandom_range(0, 1));
      tick("rnd");
    end

    // Cascade: 3600 ticks plus flush cycles for the minutes stage to wrap.
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    c_rst = 1'b0; c_tick = 1'b1;
    chk("casc_rst.sec", s_val, 0); chk("casc_rst.min", m_val, 0);
    sec_pulses = 0; min_pulses = 0;
    for (int i = 0; i < 3603; i++) begin
      if (i == 3600) c_tick = 1'b0;
      @(posedge clk); #1;
      if (s_ovf) sec_pulses++;
      if (m_ovf) min_pulses++;
      if (i == 3599) begin
        chk("casc_3600.sec", s_val, 0);
        chk("casc_3600.min", m_val, 59);
      end
    end
    chk("casc.sec_val", s_val, 0);
    chk("casc.min_val", m_val, 0);
    chk("casc.min_digits", {m_high, m_low}, 8'h00);
    chk("casc.sec_pulses", sec_pulses, 60);
    chk("casc.min_pulses", min_pulses, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_bcd_counter.md
Name: mod_bcd_counter

Overview:
- Parametrised successor to the stopwatch seconds/minutes counter.
- Modulo-MODULUS up/down counter with a cascadable one-cycle overflow pulse, synchronous preset load, and a choice of wrap or saturate at the range ends.
- Optional step suppression on the cycle a direction change is detected.
- Registered two-digit BCD outputs for the seven-segment display path.
- Instances chain through ovf -> clk_en to form seconds, minutes and hours stages.

Parameters:
- MODULUS, 60: count range 0..MODULUS-1. Legal values are 2..100; elaboration fails outside that range.
- WIDTH, 7: binary width of val. Must satisfy 2**WIDTH >= MODULUS.
- WRAP, 1: 1 = wrap at range ends; 0 = saturate at range ends.
- SKIP_ON_DIR, 1: 1 = honour skip_dir; 0 = skip_dir ignored.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- clk_en  in  1  step enable (tick or upstream ovf)
- back  in  1  direction: 0 = up, 1 = down
- skip_dir  in  1  suppress the step in a cycle where back differs from its previous-cycle value
- load  in  1  synchronous preset strobe
- load_val  in  WIDTH  preset value
- val  out  WIDTH  binary count
- high_val  out  4  BCD tens digit of val
- low_val  out  4  BCD units digit of val
- ovf  out  1  one-cycle boundary pulse
- sat  out  1  level: count is clamped at a range end (WRAP=0 only)

Behaviour:
- Reset (rst=1 at posedge):
  - val=0, high_val=0, low_val=0, ovf=0, sat=0.
  - last_back is sampled every cycle, including during reset.
- Priority per cycle: rst > load > step > idle.
- last_back <= back every cycle.
- dir_change = (last_back != back).
- step = clk_en && !(SKIP_ON_DIR && skip_dir && dir_change).
- Load:
  - val <= min(load_val, MODULUS-1); out-of-range values clamp to MODULUS-1.
  - ovf <= 0; sat <= 0.
  - clk_en is ignored in the load cycle.
- Step up (back=0):
  - val < MODULUS-1: val+1, ovf=0.
  - val == MODULUS-1, WRAP=1: val=0, ovf=1.
  - val == MODULUS-1, WRAP=0: val holds, ovf=0, sat=1.
- Step down (back=1):
  - val > 0: val-1, ovf=0.
  - val == 0, WRAP=1: val=MODULUS-1, ovf=1.
  - val == 0, WRAP=0: val holds, ovf=0, sat=1.
- sat clears on the first step that moves val, or on load or rst.
- No step: val holds, ovf=0, sat holds.
- ovf timing: asserted in the same cycle the wrapped val is visible, for exactly one cycle. A downstream stage seeing ovf as its clk_en steps on the next edge.
- Digits:
  - high_val/low_val are registered from the next-state value of val.
  - They are always consistent with val in the same cycle; zero extra latency.
  - high_val = val/10, low_val = val%10.
- Arithmetic:
  - All compares are at WIDTH bits.
  - val never leaves 0..MODULUS-1 under any input sequence.
- Simultaneous events:
  - rst with load: reset wins.
  - load with clk_en: load wins, ovf=0.
  - Direction change with skip_dir=0: steps normally in the new direction.
- Reset mid-operation: reset takes effect at the next edge regardless of any pending ovf pulse; the ovf pulse is dropped.

Decomposition:
- Shared package stopwatch_pkg:
  - DIGIT_W = 4.
  - Function bcd_tens(val), function bcd_units(val).
  - Constants SEC_MOD = 60, MIN_MOD = 60, HR_MOD = 24.
- One sub-module, bin2bcd2: combinational binary-to-two-digit BCD conversion (0..99), instantiated on the next-state value ahead of the digit registers.

Test Plan:
- Up wrap: MODULUS=60, WRAP=1, back=0, clk_en=1 from val=58 -> val 59 (ovf=0), then 0 with ovf=1 for one cycle; high_val=0, low_val=0.
- Down wrap: back=1 from val=1 -> 0 (ovf=0), then 59 with ovf=1; high_val=5, low_val=9.
- Direction skip: val=30, back toggles 0->1 with skip_dir=1, clk_en=1 -> val stays 30 that cycle, 29 the next. Same with skip_dir=0 -> 29 immediately.
- Load clamp: load=1, load_val=75, clk_en=1 -> val=59, high_val=5, low_val=9, ovf=0. load_val=42 -> val=42.
- Saturate: WRAP=0, MODULUS=24, val=23, up step -> val=23, sat=1, ovf=0. Next down step -> 22, sat=0.
- Reset priority and cascade:
  - rst=1 with load=1 at val=59 -> val=0, ovf=0.
  - Two chained instances (60, 60) run 3600 ticks -> both read 0 and the upper stage ovf pulses exactly once.
